// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
// State encoding and default operand width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mult_state_t;

    localparam int MULT_DEF_WIDTH = 8;

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-and-add datapath: accumulator, shifting multiplicand and multiplier.
// The next accumulator value is exported so the final add lands in product.
module shift_add_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_nxt_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    always_comb begin
        acc_nxt_o = acc_q;
        if (mplier_q[0]) begin
            acc_nxt_o = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (step_i) begin
            acc_q    <= acc_nxt_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Fixed latency: done is high WIDTH cycles after the accepting edge.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               load, step;
    logic [2*WIDTH-1:0] acc_nxt;

    shift_add_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .a_i       (a),
        .b_i       (b),
        .acc_nxt_o (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    // Final iteration: capture the sum being written this edge
                    product_d = acc_nxt;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult at WIDTH = 8.
module tb_shift_add_mult;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           ready;
    logic           done;
    logic [2*W-1:0] product;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;
    bit   chk_rdy = 1'b0;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_rdy) begin
                check("ready_after_done", ready, 1);
                chk_rdy = 1'b0;
            end
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", product, e.prod);
                    check("latency", cyc, e.due);
                    check("ready_during_done", ready, 0);
                    chk_rdy = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2*W-1:0] p, input bit push);
        exp_t e;
        wait_ready();
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'hA5;
        b = 8'h5A;
        if (push) begin
            e.prod = p;
            e.due = cyc + W;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int e0;
        exp_t e;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", ready, 1);
            check("rst_done", done, 0);
            check("rst_product", product, 0);
        end

        issue(8'd13, 8'd11, 16'd143, 1'b1);
        drain();

        issue(8'd255, 8'd255, 16'd65025, 1'b1);
        issue(8'd0, 8'd200, 16'd0, 1'b1);
        drain();

        d0 = n_done;
        issue(8'd5, 8'd9, 16'd45, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'd3;
        b = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("busy_start_ignored", n_done - d0, 1);

        issue(8'd100, 8'd100, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        d0 = n_done;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_done", n_done - d0, 0);
        check("midrst_product_hold", product, 0);

        wait_ready();
        a = 8'd7;
        b = 8'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.prod = 16'd42;
            e.due = e0 + W + k * (W + 2);
            exp_q.push_back(e);
        end
        repeat (25) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
